// File: rtl/e_mult_div_unit.sv
// E-stage multiply/divide unit with architectural HI/LO: mult/div results commit after a fixed busy window,
// mthi/mtlo write in one cycle, mfhi/mflo read combinationally; ops arriving while busy are ignored (stall is upstream).
module e_mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  output logic        E_MD_Start,
  output logic        E_MD_Busy,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO,
  output logic [31:0] E_MD_Out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] MULT_N = MULT_CYCLES[3:0];
  localparam logic [3:0] DIV_N  = DIV_CYCLES[3:0];

  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] tmp_hi_q, tmp_hi_d;
  logic [31:0] tmp_lo_q, tmp_lo_d;
  logic        wr_q, wr_d;

  logic        idle;
  logic        b_zero;
  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic [31:0] a_mag, b_mag, mag_q, mag_r, sdiv_q, sdiv_r;
  logic [31:0] udiv_b, udiv_q, udiv_r;

  assign idle   = (cnt_q == 4'd0);
  assign b_zero = (E_B == 32'd0);

  // Low 64 bits of a product of sign-extended operands equal the signed 32x32 product.
  assign a_sx   = {{32{E_A[31]}}, E_A};
  assign b_sx   = {{32{E_B[31]}}, E_B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, E_A} * {32'd0, E_B};

  // Signed divide on magnitudes: handles 0x80000000 / -1 without overflow.
  assign a_mag  = E_A[31] ? (32'd0 - E_A) : E_A;
  assign b_mag  = b_zero ? 32'd1 : (E_B[31] ? (32'd0 - E_B) : E_B);
  assign mag_q  = a_mag / b_mag;
  assign mag_r  = a_mag % b_mag;
  assign sdiv_q = (E_A[31] ^ E_B[31]) ? (32'd0 - mag_q) : mag_q;
  assign sdiv_r = E_A[31] ? (32'd0 - mag_r) : mag_r;

  assign udiv_b = b_zero ? 32'd1 : E_B;
  assign udiv_q = E_A / udiv_b;
  assign udiv_r = E_A % udiv_b;

  always_comb begin
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    wr_d     = wr_q;
    if (!idle) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1 && wr_q) begin
        hi_d = tmp_hi_q;
        lo_d = tmp_lo_q;
      end
    end else begin
      case (E_MDOp)
        OP_MULT: begin
          tmp_hi_d = prod_s[63:32];
          tmp_lo_d = prod_s[31:0];
          wr_d     = 1'b1;
          cnt_d    = MULT_N;
        end
        OP_MULTU: begin
          tmp_hi_d = prod_u[63:32];
          tmp_lo_d = prod_u[31:0];
          wr_d     = 1'b1;
          cnt_d    = MULT_N;
        end
        OP_DIV: begin
          tmp_hi_d = sdiv_r;
          tmp_lo_d = sdiv_q;
          wr_d     = !b_zero;
          cnt_d    = DIV_N;
        end
        OP_DIVU: begin
          tmp_hi_d = udiv_r;
          tmp_lo_d = udiv_q;
          wr_d     = !b_zero;
          cnt_d    = DIV_N;
        end
        OP_MTHI: hi_d = E_A;
        OP_MTLO: lo_d = E_A;
        default: ;
      endcase
    end
    busy_d = (cnt_d != 4'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= 4'd0;
      busy_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      tmp_hi_q <= 32'd0;
      tmp_lo_q <= 32'd0;
      wr_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      wr_q     <= wr_d;
    end
  end

  assign E_MD_Start = idle && (E_MDOp >= OP_MULT) && (E_MDOp <= OP_DIVU);
  assign E_MD_Busy  = busy_q;
  assign E_HI       = hi_q;
  assign E_LO       = lo_q;

  always_comb begin
    case (E_MDOp)
      OP_MFHI: E_MD_Out = hi_q;
      OP_MFLO: E_MD_Out = lo_q;
      default: E_MD_Out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_mult_div_unit.sv
// Bench for e_mult_div_unit: directed vector table, hand-written reset/mf sequences, random ops vs an arithmetic model.
module tb_e_mult_div_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  E_MDOp = 4'd0;
  logic [31:0] E_A = 32'd0;
  logic [31:0] E_B = 32'd0;
  logic        E_MD_Start, E_MD_Busy;
  logic [31:0] E_HI, E_LO, E_MD_Out;

  e_mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .E_MDOp(E_MDOp), .E_A(E_A), .E_B(E_B),
    .E_MD_Start(E_MD_Start), .E_MD_Busy(E_MD_Busy),
    .E_HI(E_HI), .E_LO(E_LO), .E_MD_Out(E_MD_Out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  // Hazard monitor: the stall unit must never present an MD op while the unit is busy.
  logic haz_seen = 1'b0;
  always @(posedge clk) begin
    if (!reset && E_MD_Busy && E_MDOp >= 4'd1 && E_MDOp <= 4'd8) haz_seen <= 1'b1;
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          n;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Called just after a falling edge; returns at the falling edge where Busy reads 0 again.
  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int en, input logic [31:0] eh, input logic [31:0] el);
    int n;
    logic [31:0] eout;
    eout = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
    E_MDOp = op; E_A = a; E_B = b;
    #1;
    chk({nm, " start"}, {31'd0, E_MD_Start}, {31'd0, (op >= 4'd1 && op <= 4'd4)});
    chk({nm, " out"}, E_MD_Out, eout);
    @(negedge clk);
    E_MDOp = 4'd0; E_A = $urandom; E_B = $urandom;
    n = 0;
    while (E_MD_Busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({nm, " busy_cycles"}, 32'(n), 32'(en));
    chk({nm, " hi"}, E_HI, eh);
    chk({nm, " lo"}, E_LO, el);
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int n, output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = m_hi; l = m_lo; n = 0;
    case (op)
      4'd1: begin q = sa * sb; h = q[63:32]; l = q[31:0]; n = MULT_N; end
      4'd2: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; n = MULT_N; end
      4'd3: begin
        n = DIV_N;
        if (b != 32'd0) begin q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0]; end
      end
      4'd4: begin
        n = DIV_N;
        if (b != 32'd0) begin h = a % b; l = a / b; end
      end
      4'd7: h = a;
      4'd8: l = a;
      default: ;
    endcase
  endtask

  initial begin
    int en;
    logic [31:0] eh, el, a, b;
    logic [3:0] op;

    tbl[0] = '{4'd1, 32'hFFFFFFFD, 32'd5,        MULT_N, 32'hFFFFFFFF, 32'hFFFFFFF1};
    tbl[1] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, MULT_N, 32'hFFFFFFFE, 32'h00000001};
    tbl[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        DIV_N,  32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, DIV_N,  32'h00000000, 32'h80000000};
    tbl[4] = '{4'd7, 32'h00001234, 32'd0,        0,      32'h00001234, 32'h80000000};
    tbl[5] = '{4'd4, 32'd9,        32'd0,        DIV_N,  32'h00001234, 32'h80000000};
    tbl[6] = '{4'd4, 32'd100,      32'd7,        DIV_N,  32'h00000002, 32'h0000000E};
    tbl[7] = '{4'd3, 32'd7,        32'hFFFFFFFE, DIV_N,  32'h00000001, 32'hFFFFFFFD};
    tbl[8] = '{4'd1, 32'h00010000, 32'h00010000, MULT_N, 32'h00000001, 32'h00000000};
    tbl[9] = '{4'd8, 32'hA5A5A5A5, 32'd0,        0,      32'h00000001, 32'hA5A5A5A5};

    repeat (2) @(negedge clk);
    chk("reset busy", {31'd0, E_MD_Busy}, 32'd0);
    chk("reset hi", E_HI, 32'd0);
    chk("reset lo", E_LO, 32'd0);
    chk("reset out", E_MD_Out, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Each entry starts in the very cycle the previous op's Busy dropped.
    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].n, tbl[i].hi, tbl[i].lo);

    run_op("mthi", 4'd7, 32'hCAFEBABE, 32'd0, 0, 32'hCAFEBABE, m_lo);
    run_op("mfhi", 4'd5, 32'd0, 32'd0, 0, 32'hCAFEBABE, m_lo);
    run_op("mflo", 4'd6, 32'd0, 32'd0, 0, m_hi, m_lo);
    run_op("none", 4'd0, 32'hFFFFFFFF, 32'd1, 0, m_hi, m_lo);
    run_op("op12", 4'd12, 32'hFFFFFFFF, 32'd1, 0, m_hi, m_lo);

    // Reset on the 4th busy cycle of a divide.
    run_op("pre_hi", 4'd7, 32'h55, 32'd0, 0, 32'h55, m_lo);
    run_op("pre_lo", 4'd8, 32'h66, 32'd0, 0, m_hi, 32'h66);
    E_MDOp = 4'd3; E_A = 32'd100; E_B = 32'd3;
    @(negedge clk);
    E_MDOp = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_mid busy_before", {31'd0, E_MD_Busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid busy", {31'd0, E_MD_Busy}, 32'd0);
    chk("rst_mid hi", E_HI, 32'd0);
    chk("rst_mid lo", E_LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    run_op("post_rst_mult", 4'd1, 32'd2, 32'd3, MULT_N, 32'd0, 32'd6);

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 12));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'h80000000;
        2: b = 32'hFFFFFFFF;
        3: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      model(op, a, b, en, eh, el);
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, en, eh, el);
    end

    chk("hazard_monitor", {31'd0, haz_seen}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
